// File: rtl/bfs_pkg.sv
// Shared BFS datapath definitions: address width helper, visited-stage timing
// and the candidate filter FSM encoding.
package bfs_pkg;

  function automatic int ADDR_W(input int proc_bits);
    return 32 + proc_bits;
  endfunction

  localparam int NUM_VERTICES_DEFAULT = 1024;
  localparam int VISITED_LAT_HIT      = 3;
  localparam int VISITED_LAT_MISS     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } filter_state_t;

endpackage

// File: rtl/frontier_fifo.sv
// Synchronous first-word-fall-through FIFO holding newly discovered frontier
// vertices. The head is valid in the same cycle empty_o is low.
module frontier_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so push while full is legal then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/visit_filter.sv
// Candidate filter in front of the visited-bitmap stage: one lookup in flight,
// newly visited vertices go to the frontier FIFO, revisits are counted.
module visit_filter
  import bfs_pkg::*;
#(
  parameter int PROC_BITS    = 0,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_VERTICES = NUM_VERTICES_DEFAULT,
  parameter int TIMEOUT      = 15
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [32+PROC_BITS-1:0] nbr_addr_in,
  input  logic                   nbr_valid_in,
  output logic                   nbr_ready_out,
  output logic [32+PROC_BITS-1:0] v_addr_out,
  output logic                   v_addr_valid_out,
  input  logic                   visited_in,
  input  logic                   valid_v_in,
  output logic [32+PROC_BITS-1:0] frontier_addr_out,
  output logic                   frontier_valid_out,
  input  logic                   frontier_ready_in,
  output logic [15:0]            dropped_count_out,
  output logic                   range_err_out,
  output logic                   timeout_err_out,
  output logic                   busy_out
);

  localparam int AW = ADDR_W(PROC_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  filter_state_t state_q, state_d;
  logic [AW-1:0] vaddr_q, vaddr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   drop_q, drop_d;
  logic          rerr_q, rerr_d;
  logic          terr_q, terr_d;
  logic          push, accept, out_of_range;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Ready only with a free slot: the eventual push can then never overflow.
  assign nbr_ready_out = !rst_in && (state_q == IDLE) && !fifo_full;
  assign accept        = nbr_valid_in && nbr_ready_out;
  assign out_of_range  = (nbr_addr_in >= AW'(NUM_VERTICES));

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    rerr_d  = rerr_q;
    terr_d  = terr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (out_of_range) begin
            rerr_d = 1'b1;
          end else begin
            vaddr_d = nbr_addr_in;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (valid_v_in) begin
          if (!visited_in)          push   = 1'b1;
          else if (drop_q != '1)    drop_d = drop_q + 16'd1;
          state_d = IDLE;
        end else if (int'(tmo_q) + 1 >= TIMEOUT) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      vaddr_q <= '0;
      tmo_q   <= '0;
      drop_q  <= '0;
      rerr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      rerr_q  <= rerr_d;
      terr_q  <= terr_d;
    end
  end

  frontier_fifo #(
    .WIDTH (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .push_i      (push),
    .push_data_i (vaddr_q),
    .pop_i       (frontier_ready_in),
    .head_o      (frontier_addr_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign v_addr_out         = vaddr_q;
  assign v_addr_valid_out   = (state_q == ISSUE);
  assign frontier_valid_out = !fifo_empty;
  assign dropped_count_out  = drop_q;
  assign range_err_out      = rerr_q;
  assign timeout_err_out    = terr_q;
  assign busy_out           = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_visit_filter.sv
// Bench for visit_filter: a behavioural visited-stage responder, a set-based
// reference model of which vertices reach the frontier, and random traffic.
module tb_visit_filter;

  localparam int NV = 1024;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] nbr_addr_in = '0;
  logic        nbr_valid_in = 1'b0;
  logic        nbr_ready_out;
  logic [31:0] v_addr_out;
  logic        v_addr_valid_out;
  logic        visited_in = 1'b0;
  logic        valid_v_in = 1'b0;
  logic [31:0] frontier_addr_out;
  logic        frontier_valid_out;
  logic        frontier_ready_in = 1'b0;
  logic [15:0] dropped_count_out;
  logic        range_err_out;
  logic        timeout_err_out;
  logic        busy_out;

  visit_filter dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .nbr_addr_in        (nbr_addr_in),
    .nbr_valid_in       (nbr_valid_in),
    .nbr_ready_out      (nbr_ready_out),
    .v_addr_out         (v_addr_out),
    .v_addr_valid_out   (v_addr_valid_out),
    .visited_in         (visited_in),
    .valid_v_in         (valid_v_in),
    .frontier_addr_out  (frontier_addr_out),
    .frontier_valid_out (frontier_valid_out),
    .frontier_ready_in  (frontier_ready_in),
    .dropped_count_out  (dropped_count_out),
    .range_err_out      (range_err_out),
    .timeout_err_out    (timeout_err_out),
    .busy_out           (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a vertex reaches the frontier the first time it is looked up.
  bit          seen   [NV];
  bit          bitmap [NV];
  logic [31:0] exp_q [$];
  int          exp_drop;
  bit          exp_range, exp_timeout;
  bit          resp_en   = 1'b1;
  bit          rand_cons = 1'b0;
  logic        man_ready = 1'b0;
  int          strobes   = 0;
  logic [31:0] last_strobe = '0;
  logic [31:0] last_pop = '1;

  task automatic model_accept(input logic [31:0] a);
    if (a >= NV)               exp_range = 1'b1;
    else if (!resp_en)         exp_timeout = 1'b1;
    else if (seen[a[9:0]])     begin if (exp_drop < 16'hFFFF) exp_drop++; end
    else begin
      seen[a[9:0]] = 1'b1;
      exp_q.push_back(a);
    end
  endtask

  task automatic model_reset(input bit clear_bitmap);
    exp_q.delete();
    exp_drop = 0; exp_range = 0; exp_timeout = 0;
    if (clear_bitmap) for (int i = 0; i < NV; i++) begin seen[i] = 0; bitmap[i] = 0; end
  endtask

  task automatic do_reset(input bit clear_bitmap);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    model_reset(clear_bitmap);
  endtask

  task automatic send(input logic [31:0] a, input int budget, output bit acc);
    nbr_addr_in = a; nbr_valid_in = 1'b1; acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk_in);
      if (nbr_ready_out) acc = 1'b1;
      @(posedge clk_in); #1;
    end
    nbr_valid_in = 1'b0;
    if (acc) model_accept(a);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy_out) break;
      @(posedge clk_in); #1;
    end
    chk("idle_wait", busy_out, 0);
  endtask

  task automatic check_reset_outs();
    chk("rst_nbr_ready", nbr_ready_out, 0);
    chk("rst_v_addr", v_addr_out, 0);
    chk("rst_v_valid", v_addr_valid_out, 0);
    chk("rst_fr_addr", frontier_addr_out, 0);
    chk("rst_fr_valid", frontier_valid_out, 0);
    chk("rst_dropped", dropped_count_out, 0);
    chk("rst_range", range_err_out, 0);
    chk("rst_timeout", timeout_err_out, 0);
    chk("rst_busy", busy_out, 0);
  endtask

  // Visited stage: answers each strobe after the hit/miss latency, checks the
  // address is held and no second strobe appears while the lookup is open.
  initial begin
    logic [31:0] a;
    bit hit, aborted;
    int lat;
    forever begin
      @(negedge clk_in);
      if (v_addr_valid_out && !rst_in) begin
        a = v_addr_out; strobes++; last_strobe = a;
        if (resp_en) begin
          hit = bitmap[a[9:0]];
          lat = hit ? 3 : 4;
          aborted = 1'b0;
          for (int k = 1; k <= lat; k++) begin
            @(posedge clk_in); #3;
            if (rst_in) aborted = 1'b1;
            if (k < lat && !aborted) begin
              chk("vaddr_hold", v_addr_out, a);
              chk("strobe_dup", v_addr_valid_out, 0);
            end
          end
          valid_v_in = 1'b1; visited_in = hit;
          if (!hit) bitmap[a[9:0]] = 1'b1;
          @(posedge clk_in); #3;
          valid_v_in = 1'b0; visited_in = 1'b0;
        end
      end
    end
  end

  // Frontier consumer: drives ready and checks every pop against the model.
  initial forever begin
    @(posedge clk_in); #2;
    frontier_ready_in = rand_cons ? 1'($urandom_range(0, 1)) : man_ready;
  end

  initial forever begin
    @(negedge clk_in);
    if (frontier_valid_out && frontier_ready_in && !rst_in) begin
      if (exp_q.size() == 0) chk("pop_unexpected", frontier_addr_out, 32'hFFFF_FFFF);
      else chk("pop_head", frontier_addr_out, exp_q.pop_front());
      last_pop = frontier_addr_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int s0, n_acc;
    logic [31:0] a;

    // Reset state
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check_reset_outs();
    rst_in = 1'b0;
    model_reset(1'b1);

    // New vertex 5: one strobe, pushed to the frontier
    s0 = strobes;
    send(32'd5, 10, acc);
    chk("acc_5", acc, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      if (frontier_valid_out) break;
    end
    chk("strobe_once", strobes - s0, 1);
    chk("strobe_addr", last_strobe, 5);
    chk("fr_valid_5", frontier_valid_out, 1);
    chk("fr_head_5", frontier_addr_out, 5);
    man_ready = 1'b1; @(posedge clk_in); #1; man_ready = 1'b0;
    wait_idle(20);
    chk("pop_5", last_pop, 5);

    // Vertex 5 again: already visited, dropped
    send(32'd5, 10, acc);
    wait_idle(20);
    chk("drop_1", dropped_count_out, 1);
    chk("no_push_hit", frontier_valid_out, 0);

    // Fill the frontier: exactly 16 accepted while nothing drains
    do_reset(1'b1);
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'(i), 30, acc);
      n_acc += int'(acc);
    end
    chk("fill_accepts", n_acc, 16);
    send(32'd16, 40, acc);
    chk("full_blocks", acc, 0);
    chk("full_ready", nbr_ready_out, 0);
    man_ready = 1'b1; @(posedge clk_in); #1; man_ready = 1'b0;
    @(posedge clk_in); #1;
    chk("full_pop_head", last_pop, 0);
    send(32'd16, 10, acc);
    chk("after_pop_acc", acc, 1);
    man_ready = 1'b1;
    wait_idle(200);
    man_ready = 1'b0;
    chk("fill_drained", exp_q.size(), 0);

    // Out-of-range address
    s0 = strobes;
    send(32'd1024, 5, acc);
    chk("range_acc", acc, 1);
    chk("range_err", range_err_out, 1);
    @(negedge clk_in);
    chk("range_ready", nbr_ready_out, 1);
    repeat (3) @(posedge clk_in); #1;
    chk("range_no_strobe", strobes - s0, 0);

    // Silent visited stage: timeout after 15 WAIT cycles
    resp_en = 1'b0;
    send(32'd7, 5, acc);
    repeat (15) begin @(posedge clk_in); #1; end
    chk("tmo_not_yet", timeout_err_out, 0);
    @(posedge clk_in); #1;
    chk("tmo_err", timeout_err_out, exp_timeout);
    chk("tmo_idle", busy_out, 0);
    chk("tmo_no_push", frontier_valid_out, 0);
    resp_en = 1'b1;

    // Reset during WAIT with three entries queued; late response ignored
    for (int i = 0; i < 3; i++) begin
      send(32'(200 + i), 10, acc);
      repeat (8) begin @(posedge clk_in); #1; end
    end
    send(32'd203, 10, acc);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_reset_outs();
    rst_in = 1'b0;
    model_reset(1'b0);
    s0 = strobes;
    repeat (8) begin @(posedge clk_in); #1; end
    chk("late_resp_fr", frontier_valid_out, 0);
    chk("late_resp_busy", busy_out, 0);
    chk("late_resp_drop", dropped_count_out, 0);
    chk("late_resp_strobe", strobes - s0, 0);

    // Random traffic with a random consumer
    do_reset(1'b1);
    rand_cons = 1'b1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
      a = ($urandom_range(0, 9) == 0) ? 32'(1024 + $urandom_range(0, 100))
                                      : 32'($urandom_range(0, 47));
      send(a, 100, acc);
      chk("rand_acc", acc, 1);
    end
    rand_cons = 1'b0;
    man_ready = 1'b1;
    wait_idle(300);
    chk("rand_drop", dropped_count_out, exp_drop);
    chk("rand_range", range_err_out, exp_range);
    chk("rand_timeout", timeout_err_out, 0);
    chk("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
